// File: rtl/phy_tx_sched.sv
// Round-robin burst scheduler: four FWFT requesters share one phy_tx word lane.
// Grants one requester per burst, pops its words and presents them on input_bus/valid.
//
// state | meaning
// ARB   | search requesters round-robin from last_grant+1, grant the first non-empty
// SEND  | pop granted FIFO one word per unpaused cycle, up to MAX_BURST words
// GAP   | enforced idle between bursts, GAP cycles long
module phy_tx_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4,
  parameter int GAP        = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              req_empty,
  input  logic [4*DATA_WIDTH-1:0] req_data,
  input  logic                    pause,
  output logic [3:0]              pop,
  output logic [DATA_WIDTH-1:0]   input_bus,
  output logic                    valid,
  output logic [1:0]              grant,
  output logic                    active
);

  typedef enum logic [1:0] {
    ST_ARB  = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);
  localparam logic [2:0] GAP_LAST   = (GAP > 0) ? 3'(GAP - 1) : 3'd0;
  localparam state_t     EXIT_STATE = (GAP > 0) ? ST_GAP : ST_ARB;

  state_t                state, state_nxt;
  logic [1:0]            grant_nxt;
  logic [1:0]            last_grant, last_grant_nxt;
  logic [3:0]            burst_cnt, burst_cnt_nxt;
  logic [2:0]            gap_cnt, gap_cnt_nxt;
  logic [DATA_WIDTH-1:0] bus_nxt;
  logic                  valid_nxt;
  logic [DATA_WIDTH-1:0] req_word [4];
  logic [DATA_WIDTH-1:0] head_word;
  logic                  arb_found;
  logic [1:0]            arb_idx;
  logic                  take;

  for (genvar i = 0; i < 4; i++) begin : g_word
    assign req_word[i] = req_data[DATA_WIDTH*i +: DATA_WIDTH];
  end

  assign head_word = req_word[grant];
  assign active    = (state == ST_SEND);

  // Reset gates pop combinationally so a word is never removed from a FIFO
  // in a cycle whose output register is about to be cleared.
  assign take = (state == ST_SEND) && !pause && !req_empty[grant] && !reset;
  assign pop  = take ? (4'b0001 << grant) : 4'b0000;

  always_comb begin
    logic [1:0] cand;
    arb_found = 1'b0;
    arb_idx   = last_grant;
    cand      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant + 2'(k);
      if (!arb_found && !req_empty[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    burst_cnt_nxt  = burst_cnt;
    gap_cnt_nxt    = gap_cnt;
    bus_nxt        = input_bus;
    valid_nxt      = 1'b0;
    case (state)
      ST_ARB: begin
        if (arb_found) begin
          grant_nxt      = arb_idx;
          last_grant_nxt = arb_idx;
          burst_cnt_nxt  = 4'd0;
          state_nxt      = ST_SEND;
        end
      end
      ST_SEND: begin
        if (pause) begin
          state_nxt = ST_SEND;
        end else if (req_empty[grant]) begin
          state_nxt   = EXIT_STATE;
          gap_cnt_nxt = GAP_LAST;
        end else begin
          bus_nxt       = head_word;
          valid_nxt     = 1'b1;
          burst_cnt_nxt = burst_cnt + 4'd1;
          if (burst_cnt == BURST_LAST) begin
            state_nxt   = EXIT_STATE;
            gap_cnt_nxt = GAP_LAST;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == 3'd0) state_nxt = ST_ARB;
        else                 gap_cnt_nxt = gap_cnt - 3'd1;
      end
      default: state_nxt = ST_ARB;
    endcase
  end

  // last_grant starts at 3 so requester 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_ARB;
      grant      <= 2'd0;
      last_grant <= 2'd3;
      burst_cnt  <= 4'd0;
      gap_cnt    <= 3'd0;
      input_bus  <= '0;
      valid      <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      burst_cnt  <= burst_cnt_nxt;
      gap_cnt    <= gap_cnt_nxt;
      input_bus  <= bus_nxt;
      valid      <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_phy_tx_sched.sv
// Scoreboard bench for phy_tx_sched: FIFO models feed the requesters, expected
// {grant, word} pairs are queued by the stimulus and checked by a valid monitor.
module tb_phy_tx_sched;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      req_empty;
  logic [4*DW-1:0] req_data;
  logic            pause;
  logic [3:0]      pop;
  logic [DW-1:0]   input_bus;
  logic            valid;
  logic [1:0]      grant;
  logic            active;

  logic [31:0] fq [4][$];
  logic [33:0] sb [$];
  int          vtimes [$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  phy_tx_sched #(.DATA_WIDTH(DW), .MAX_BURST(4), .GAP(1)) dut (
    .clk(clk), .reset(reset), .req_empty(req_empty), .req_data(req_data),
    .pause(pause), .pop(pop), .input_bus(input_bus), .valid(valid),
    .grant(grant), .active(active)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < 4; i++) begin
      req_empty[i] = (fq[i].size() == 0);
      req_data[i*DW +: DW] = (fq[i].size() != 0) ? fq[i][0] : 32'h0;
    end
  endtask

  // FIFO model: consume the word whose pop was high in the cycle just ended.
  always @(posedge clk) begin
    logic [3:0] p;
    p = pop;
    cyc = cyc + 1;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (p[i]) begin
        check("pop_nonempty", 64'(fq[i].size() != 0), 64'd1);
        if (fq[i].size() != 0) void'(fq[i].pop_front());
      end
    end
    drive_reqs();
  end

  always @(negedge clk) begin
    logic [33:0] e;
    if (valid === 1'b1) begin
      vtimes.push_back(cyc);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: actual grant=%0d word=%h required no valid", grant, input_bus);
      end else begin
        e = sb.pop_front();
        check("sb_word", {30'd0, grant, input_bus}, {30'd0, e});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic load(input int i, input logic [31:0] base, input int n);
    for (int j = 0; j < n; j++) fq[i].push_back(base + 32'(j));
    drive_reqs();
  endtask

  task automatic expect_words(input int g, input logic [31:0] base, input int n);
    for (int j = 0; j < n; j++) sb.push_back({2'(g), base + 32'(j)});
  endtask

  task automatic drain(input int limit);
    int k;
    k = 0;
    while (sb.size() != 0 && k < limit) begin
      tick(1);
      k++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pause = 1'b0;
    for (int i = 0; i < 4; i++) fq[i].delete();
    sb.delete();
    drive_reqs();
    tick(2);
    reset = 1'b0;
    vtimes.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int c, nv, na, run, maxrun, npop, cl;
    reset = 1'b1;
    pause = 1'b0;
    drive_reqs();

    // Reset values, then 20 idle cycles
    tick(3);
    check("rst_pop", 64'(pop), 64'd0);
    check("rst_bus", 64'(input_bus), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_active", 64'(active), 64'd0);
    reset = 1'b0;
    nv = 0; na = 0;
    repeat (20) begin
      @(negedge clk);
      if (valid) nv++;
      if (active) na++;
    end
    check("idle_valid", 64'(nv), 64'd0);
    check("idle_active", 64'(na), 64'd0);
    tick(1);

    // Requester 2, six words: burst of 4, two idle cycles, then 2
    vtimes.delete();
    c = cyc;
    load(2, 32'hA0000001, 6);
    expect_words(2, 32'hA0000001, 6);
    run = 0; maxrun = 0; npop = 0;
    repeat (20) begin
      @(negedge clk);
      if (pop == 4'b0100) begin
        run++; npop++;
        if (run > maxrun) maxrun = run;
      end else run = 0;
    end
    drain(10);
    check("t2_pop_run", 64'(maxrun), 64'd4);
    check("t2_pop_total", 64'(npop), 64'd6);
    check("t2_nwords", 64'(vtimes.size()), 64'd6);
    if (vtimes.size() >= 6) begin
      check("t2_latency", 64'(vtimes[0] - c), 64'd2);
      check("t2_back2back", 64'(vtimes[3] - vtimes[0]), 64'd3);
      check("t2_gap", 64'(vtimes[4] - vtimes[3]), 64'd3);
    end
    check("t2_grant", 64'(grant), 64'd2);

    // All four requesters, two words each: order 0..3, short bursts
    do_reset();
    for (int i = 0; i < 4; i++) begin
      load(i, 32'hB0000001 + (32'(i) << 16), 2);
      expect_words(i, 32'hB0000001 + (32'(i) << 16), 2);
    end
    drain(60);
    tick(5);
    check("t3_nwords", 64'(vtimes.size()), 64'd8);
    if (vtimes.size() >= 3) check("t3_short_gap", 64'(vtimes[2] - vtimes[1]), 64'd4);
    check("t3_idle_active", 64'(active), 64'd0);
    check("t3_last_grant", 64'(grant), 64'd3);

    // Pause for 3 cycles after word 2
    do_reset();
    c = cyc;
    load(1, 32'hC0000001, 4);
    expect_words(1, 32'hC0000001, 4);
    tick(3);
    pause = 1'b1;
    #1;
    check("t4_pause_pop", 64'(pop), 64'd0);
    check("t4_pause_active", 64'(active), 64'd1);
    @(negedge clk);
    check("t4_valid_w2", 64'(valid), 64'd1);
    @(negedge clk);
    check("t4_valid_drop", 64'(valid), 64'd0);
    tick(2);
    pause = 1'b0;
    drain(20);
    check("t4_nwords", 64'(vtimes.size()), 64'd4);
    if (vtimes.size() >= 4) begin
      check("t4_resume", 64'(vtimes[2] - vtimes[1]), 64'd4);
      check("t4_w4", 64'(vtimes[3] - vtimes[2]), 64'd1);
    end

    // Reset pulse in the third SEND cycle
    do_reset();
    load(2, 32'hD0000001, 4);
    expect_words(2, 32'hD0000001, 2);
    tick(3);
    reset = 1'b1;
    #1;
    check("t5_rst_pop", 64'(pop), 64'd0);
    tick(1);
    check("t5_valid", 64'(valid), 64'd0);
    check("t5_grant", 64'(grant), 64'd0);
    check("t5_active", 64'(active), 64'd0);
    reset = 1'b0;
    load(0, 32'hE0000001, 1);
    load(3, 32'hF0000001, 1);
    expect_words(0, 32'hE0000001, 1);
    expect_words(2, 32'hD0000003, 2);
    expect_words(3, 32'hF0000001, 1);
    drain(60);

    // Empty and pause rise together in SEND
    do_reset();
    load(3, 32'h90000001, 1);
    expect_words(3, 32'h90000001, 1);
    tick(2);
    pause = 1'b1;
    tick(1);
    check("t6_stay_active", 64'(active), 64'd1);
    check("t6_no_pop", 64'(pop), 64'd0);
    tick(1);
    pause = 1'b0;
    tick(1);
    check("t6_exit_active", 64'(active), 64'd0);
    check("t6_exit_valid", 64'(valid), 64'd0);
    cl = cyc;
    load(3, 32'h90000002, 1);
    expect_words(3, 32'h90000002, 1);
    drain(20);
    check("t6_nwords", 64'(vtimes.size()), 64'd2);
    if (vtimes.size() >= 2) check("t6_via_gap", 64'(vtimes[1] - cl), 64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
